if_fetch_unit: RTL and testbench

- Instruction-fetch producer for the 5-stage MIPS pipeline: owns the PC, issues single-outstanding requests to instruction memory, and presents instruction, PC and PC+4 to the IF/ID pipeline register.
- The IF/ID register consumes this block's outputs; the hazard unit supplies stall_in and the branch/jump resolution supplies redirect.
- Valid/ready handshake toward IF/ID: ready = ~stall_in.

---
 rtl/if_fetch_unit_pkg.sv | 37 +++
 rtl/if_pc_reg.sv | 29 ++
 rtl/if_fetch_unit.sv | 212 +++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM state encoding,
// default reset PC, NOP word, PC increment and address-alignment helpers.
// Optional build macro: IF_FETCH_ALIGN_CHECK_EN (adds the S_FAULT state).
package if_fetch_unit_pkg;

`ifdef IF_FETCH_ALIGN_CHECK_EN
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FULL  = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FULL  = 2'd3
  } fetch_state_t;
`endif

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // True when a byte address is not word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program-counter register for the fetch unit.
// Update priority: reset > load (redirect) > increment > hold.
module if_pc_reg
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic        incr,
  output logic [31:0] pc
);

  // PC update with reset/redirect/increment priority; wraps modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (incr) begin
      pc <= pc + PC_INCR;
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer: owns the PC, issues one outstanding request
// at a time to instruction memory and presents instruction / PC / PC+4 to
// the IF/ID register with a valid (fetch_valid) / ready (~stall_in) pair.
// Optional build macro: IF_FETCH_ALIGN_CHECK_EN adds fetch_misalign and a
// fault state entered on a misaligned redirect target.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_now_out,
  output logic [31:0] pc_next4_out
`ifdef IF_FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  fetch_state_t state;
  logic         kill;     // the outstanding response belongs to a dead path
  logic [31:0]  pc;
  logic [31:0]  load_pc;
  logic         pc_incr;

`ifdef IF_FETCH_ALIGN_CHECK_EN
  logic redirect_bad;
  // A misaligned target is kept as-is so it can be inspected after the fault.
  assign load_pc      = redirect_pc;
  assign redirect_bad = redirect_valid & is_misaligned(redirect_pc);
`else
  assign load_pc = align_pc(redirect_pc);
`endif

  // PC advances only when a live response is captured into the output regs.
  always_comb begin
    pc_incr = 1'b0;
    if ((state == S_WAIT) && imem_rvalid && !kill && !redirect_valid) begin
      pc_incr = 1'b1;
    end else begin
      pc_incr = 1'b0;
    end
  end

  if_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect_valid),
    .load_pc (load_pc),
    .incr    (pc_incr),
    .pc      (pc)
  );

  // The request address is the PC register itself, so it is stable for the
  // whole issue cycle even when a redirect lands in that same cycle.
  assign imem_addr = pc;

  // Fetch FSM and all registered handshake/data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_RESET;
      kill            <= 1'b0;
      fetch_valid     <= 1'b0;
      instruction_out <= NOP_INSTR;
      pc_now_out      <= 32'h0000_0000;
      pc_next4_out    <= 32'h0000_0000;
      imem_req        <= 1'b0;
`ifdef IF_FETCH_ALIGN_CHECK_EN
      fetch_misalign  <= 1'b0;
`endif
    end else begin
      // imem_req is a one-cycle strobe raised only on entry to S_ISSUE.
      imem_req <= 1'b0;
      case (state)
        S_RESET: begin
`ifdef IF_FETCH_ALIGN_CHECK_EN
          if (redirect_bad) begin
            state          <= S_FAULT;
            fetch_misalign <= 1'b1;
          end else
`endif
          begin
            state    <= S_ISSUE;
            imem_req <= 1'b1;
          end
        end

        S_ISSUE: begin
          // The request leaves this cycle regardless; a redirect kills it.
          if (redirect_valid) begin
            kill <= 1'b1;
          end else begin
            kill <= kill;
          end
`ifdef IF_FETCH_ALIGN_CHECK_EN
          if (redirect_bad) begin
            state          <= S_FAULT;
            fetch_misalign <= 1'b1;
          end else
`endif
          begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (imem_rvalid) begin
            kill <= 1'b0;
`ifdef IF_FETCH_ALIGN_CHECK_EN
            if (redirect_bad) begin
              state          <= S_FAULT;
              fetch_misalign <= 1'b1;
            end else
`endif
            if (kill || redirect_valid) begin
              // Stale path: drop the data and fetch from the (new) PC.
              state    <= S_ISSUE;
              imem_req <= 1'b1;
            end else begin
              instruction_out <= imem_rdata;
              pc_now_out      <= pc;
              pc_next4_out    <= pc + PC_INCR;
              fetch_valid     <= 1'b1;
              state           <= S_FULL;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
`ifdef IF_FETCH_ALIGN_CHECK_EN
            if (redirect_bad) begin
              state          <= S_FAULT;
              fetch_misalign <= 1'b1;
            end else
`endif
            begin
              state <= S_WAIT;
            end
          end else begin
            state <= S_WAIT;
          end
        end

        S_FULL: begin
          if (redirect_valid) begin
            // Flush wins over stall: the held instruction is on a dead path.
            fetch_valid     <= 1'b0;
            instruction_out <= NOP_INSTR;
`ifdef IF_FETCH_ALIGN_CHECK_EN
            if (redirect_bad) begin
              state          <= S_FAULT;
              fetch_misalign <= 1'b1;
            end else
`endif
            begin
              state    <= S_ISSUE;
              imem_req <= 1'b1;
            end
          end else if (!stall_in) begin
            fetch_valid     <= 1'b0;
            instruction_out <= NOP_INSTR;
            state           <= S_ISSUE;
            imem_req        <= 1'b1;
          end else begin
            state <= S_FULL;
          end
        end

`ifdef IF_FETCH_ALIGN_CHECK_EN
        S_FAULT: begin
          // A response still in flight is drained here and never delivered.
          if (imem_rvalid) begin
            kill <= 1'b0;
          end else begin
            kill <= kill;
          end
          if (redirect_valid && !redirect_bad) begin
            fetch_misalign <= 1'b0;
            if (kill && !imem_rvalid) begin
              // Let S_WAIT swallow the outstanding response first.
              state <= S_WAIT;
            end else begin
              state    <= S_ISSUE;
              imem_req <= 1'b1;
            end
          end else begin
            state <= S_FAULT;
          end
        end
`endif

        default: begin
          state       <= S_RESET;
          kill        <= 1'b0;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit. A second instance with
// RESET_PC = 32'hFFFF_FFFC shares the stimulus to exercise PC wrap-around.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req, w_imem_req;
  logic [31:0] imem_addr, w_imem_addr;
  logic        fetch_valid, w_fetch_valid;
  logic [31:0] instruction_out, w_instruction_out;
  logic [31:0] pc_now_out, w_pc_now_out;
  logic [31:0] pc_next4_out, w_pc_next4_out;
`ifdef IF_FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign, w_fetch_misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit u_dut (
    .clk             (clk),
    .rst             (rst),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .fetch_valid     (fetch_valid),
    .instruction_out (instruction_out),
    .pc_now_out      (pc_now_out),
    .pc_next4_out    (pc_next4_out)
`ifdef IF_FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign  (fetch_misalign)
`endif
  );

  if_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_wrap (
    .clk             (clk),
    .rst             (rst),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (w_imem_req),
    .imem_addr       (w_imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .fetch_valid     (w_fetch_valid),
    .instruction_out (w_instruction_out),
    .pc_now_out      (w_pc_now_out),
    .pc_next4_out    (w_pc_next4_out)
`ifdef IF_FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign  (w_fetch_misalign)
`endif
  );

  // Compare one observed value against its expected value.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the full output bundle of the main instance.
  task automatic check_out(input string tag, input logic fv, input logic [31:0] instr,
                           input logic [31:0] pcn, input logic [31:0] pc4);
    check_eq({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, fv});
    check_eq({tag, ".instruction"}, instruction_out, instr);
    check_eq({tag, ".pc_now"}, pc_now_out, pcn);
    check_eq({tag, ".pc_next4"}, pc_next4_out, pc4);
  endtask

  // Check request strobe and, when a request is expected, its address.
  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check_eq({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) check_eq({tag, ".imem_addr"}, imem_addr, addr);
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    check_out("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    check_req("reset", 1'b0, 32'h0);

    // Cycle 0: S_RESET, no request.
    rst = 1'b0;
    check_req("c0", 1'b0, 32'h0);
    tick(); // cycle 1: first request
    check_req("c1", 1'b1, 32'h0000_0000);
    check_eq("c1.wrap_addr", w_imem_addr, 32'hFFFF_FFFC);
    tick(); // cycle 2: waiting, response arrives
    check_req("c2", 1'b0, 32'h0);
    check_eq("c2.fetch_valid", {31'd0, fetch_valid}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
    tick(); // cycle 3: first instruction valid
    imem_rvalid = 1'b0;
    check_out("c3", 1'b1, 32'h2008_0005, 32'h0000_0000, 32'h0000_0004);
    check_eq("c3.wrap_pc_now", w_pc_now_out, 32'hFFFF_FFFC);
    check_eq("c3.wrap_pc_next4", w_pc_next4_out, 32'h0000_0000);
    tick(); // cycle 4: accepted, second request
    check_req("c4", 1'b1, 32'h0000_0004);
    check_eq("c4.wrap_addr", w_imem_addr, 32'h0000_0000);
    check_eq("c4.fetch_valid", {31'd0, fetch_valid}, 32'd0);
    tick(); // cycle 5
    imem_rvalid = 1'b1; imem_rdata = 32'h2009_0003;
    tick(); // cycle 6
    imem_rvalid = 1'b0;
    check_out("c6", 1'b1, 32'h2009_0003, 32'h0000_0004, 32'h0000_0008);

    // Stall held for 4 cycles while valid: outputs frozen, no request.
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("stall", 1'b1, 32'h2009_0003, 32'h0000_0004, 32'h0000_0008);
      check_req("stall", 1'b0, 32'h0);
    end
    stall_in = 1'b0;
    tick(); // request the cycle after stall drops
    check_req("post_stall", 1'b1, 32'h0000_0008);
    check_eq("post_stall.fetch_valid", {31'd0, fetch_valid}, 32'd0);

    // Redirect while waiting; the late response must be discarded.
    tick(); // S_WAIT
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    check_req("wait_redir", 1'b0, 32'h0);
    check_eq("wait_redir.fetch_valid", {31'd0, fetch_valid}, 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check_out("killed", 1'b0, 32'h0, 32'h0000_0004, 32'h0000_0008);
    check_req("killed", 1'b1, 32'h0000_0040);

    // Redirect in the same cycle as the response.
    tick(); // S_WAIT
    imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    tick();
    imem_rvalid = 1'b0; redirect_valid = 1'b0;
    check_eq("same_cyc.fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check_eq("same_cyc.instruction", instruction_out, 32'h0);
    check_req("same_cyc", 1'b1, 32'h0000_0080);

    // Redirect during S_FULL with stall asserted: flush wins.
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222;
    tick();
    imem_rvalid = 1'b0;
    check_out("full", 1'b1, 32'h1111_2222, 32'h0000_0080, 32'h0000_0084);
    stall_in = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    tick();
    redirect_valid = 1'b0;
    check_eq("flush.fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check_eq("flush.instruction", instruction_out, 32'h0);
    check_req("flush", 1'b1, 32'h0000_0080);
    stall_in = 1'b0;

    // Misaligned redirect target.
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h3333_4444;
    tick();
    imem_rvalid = 1'b0;
    check_out("full2", 1'b1, 32'h3333_4444, 32'h0000_0080, 32'h0000_0084);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check_eq("lowbits.fetch_valid", {31'd0, fetch_valid}, 32'd0);
`ifdef IF_FETCH_ALIGN_CHECK_EN
    check_eq("lowbits.misalign", {31'd0, fetch_misalign}, 32'd1);
    check_req("lowbits", 1'b0, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    check_eq("fault_exit.misalign", {31'd0, fetch_misalign}, 32'd0);
`endif
    check_req("lowbits", 1'b1, 32'h0000_0100);

    // Reset while waiting, then a late response during the reset cycle.
    tick(); // S_WAIT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("rst_wait", 1'b0, 32'h0, 32'h0, 32'h0);
    check_req("rst_wait", 1'b0, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_rvalid = 1'b0;
    check_eq("late_rvalid.fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check_req("post_rst", 1'b1, 32'h0000_0000);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_AAAA;
    tick();
    imem_rvalid = 1'b0;
    check_out("post_rst_fetch", 1'b1, 32'h5555_AAAA, 32'h0000_0000, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
